// File: rtl/tx_arbiter_pkg.sv
// Shared types and constants for the packet round-robin transmit arbiter.
// State encoding, source-tag header nibble and requester-count limits.
package tx_arbiter_pkg;

   localparam int ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_HDR      = 3'd1,
      ST_FETCH    = 3'd2,
      ST_ISSUE    = 3'd3,
      ST_WAIT_ACK = 3'd4
   } state_t;

   localparam logic [3:0] HDR_NIBBLE = 4'hA;

   localparam int N_REQ_MIN = 2;
   localparam int N_REQ_MAX = 16;

   function automatic bit n_req_ok(input int n);
      return (n >= N_REQ_MIN) && (n <= N_REQ_MAX);
   endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// Requester-side and controller-side handshake bundle of the transmit arbiter.
// master = arbiter side, slave = requesters plus FIFO controller.
interface tx_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
);
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_ready;
   logic               tx;
   logic [7:0]         data_tx;
   logic               tx_rdy_mon;
   logic               tx_ack_mon;
   logic               busy;
   logic [ID_W-1:0]    grant_id;

   modport master (
      input  req_valid, req_data, req_last, tx_rdy_mon, tx_ack_mon,
      output req_ready, tx, data_tx, busy, grant_id
   );

   modport slave (
      output req_valid, req_data, req_last, tx_rdy_mon, tx_ack_mon,
      input  req_ready, tx, data_tx, busy, grant_id
   );
endinterface

// File: rtl/tx_arb_rr_pick.sv
// Rotating priority encoder: first set bit of req searching upward from last+1, wrapping.
// Purely combinational; valid is low when no request is set.
module tx_arb_rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last,
   output logic             valid,
   output logic [ID_W-1:0]  idx
);

   logic [ID_W-1:0] cand;

   // Walk from the farthest candidate down so the nearest hit is assigned last.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = ID_W'((int'(last) + k) % N_REQ);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/tx_arbiter.sv
// Packet round-robin arbiter onto the controller tx/data_tx byte path; optional source tag under TX_ARB_HEADER_EN.
// All outputs registered; tx held until tx_rdy_mon, next byte only after tx_ack_mon; grant held for a whole packet.
module tx_arbiter
   import tx_arbiter_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic         clk,
   input  logic         rst,
   tx_arbiter_if.master bus
);

   localparam int ID_W = $clog2(N_REQ);

   if (!n_req_ok(N_REQ)) begin : g_bad_n_req
      $error("tx_arbiter: N_REQ out of range 2..16");
   end

   state_t              state, state_nxt;
   logic                tx_q, tx_nxt;
   logic [7:0]          dat_q, dat_nxt;
   logic [N_REQ-1:0]    rdy_q, rdy_nxt;
   logic                last_q, last_nxt;
   logic                busy_q;
   logic [ID_W-1:0]     gnt_q, gnt_nxt;
   logic [ID_W-1:0]     lg_q, lg_nxt;
   logic                pick_vld;
   logic [ID_W-1:0]     pick_idx;
   logic [ID_W+2:0]     byte_off;

   tx_arb_rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req   (bus.req_valid),
      .last  (lg_q),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   assign byte_off = {gnt_q, 3'b000};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         tx_q   <= 1'b0;
         dat_q  <= 8'h00;
         rdy_q  <= '0;
         last_q <= 1'b0;
         busy_q <= 1'b0;
         gnt_q  <= '0;
         lg_q   <= ID_W'(N_REQ - 1);
      end else begin
         state  <= state_nxt;
         tx_q   <= tx_nxt;
         dat_q  <= dat_nxt;
         rdy_q  <= rdy_nxt;
         last_q <= last_nxt;
         busy_q <= (state_nxt != ST_IDLE);
         gnt_q  <= gnt_nxt;
         lg_q   <= lg_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tx_nxt    = tx_q;
      dat_nxt   = dat_q;
      rdy_nxt   = '0;
      last_nxt  = last_q;
      gnt_nxt   = gnt_q;
      lg_nxt    = lg_q;
      case (state)
         ST_IDLE: begin
            if (pick_vld) begin
               gnt_nxt = pick_idx;
`ifdef TX_ARB_HEADER_EN
               state_nxt = ST_HDR;
`else
               state_nxt = ST_FETCH;
`endif
            end
         end
`ifdef TX_ARB_HEADER_EN
         ST_HDR: begin
            dat_nxt   = {HDR_NIBBLE, 4'(gnt_q)};
            last_nxt  = 1'b0;
            tx_nxt    = 1'b1;
            state_nxt = ST_ISSUE;
         end
`endif
         // Byte is consumed on this edge; the requester sees the ready pulse one cycle later.
         ST_FETCH: begin
            if (bus.req_valid[gnt_q]) begin
               dat_nxt        = bus.req_data[byte_off +: 8];
               last_nxt       = bus.req_last[gnt_q];
               rdy_nxt[gnt_q] = 1'b1;
               tx_nxt         = 1'b1;
               state_nxt      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus.tx_rdy_mon) begin
               tx_nxt    = 1'b0;
               state_nxt = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (bus.tx_ack_mon) begin
               if (last_q) begin
                  lg_nxt    = gnt_q;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_FETCH;
               end
            end
         end
         default: begin
            tx_nxt    = 1'b0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bus.tx        = tx_q;
   assign bus.data_tx   = dat_q;
   assign bus.req_ready = rdy_q;
   assign bus.busy      = busy_q;
   assign bus.grant_id  = gnt_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: requester and controller models stepped once per cycle at the falling edge.
// Build with or without TX_ARB_HEADER_EN; expected byte streams account for the source-tag byte.
module tb_tx_arbiter;

   localparam int N = 4;
`ifdef TX_ARB_HEADER_EN
   localparam int NB = 1;
`else
   localparam int NB = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tx_arbiter_if #(.N_REQ(N)) bus ();

   tx_arbiter #(.N_REQ(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // requester model
   logic [7:0] pm [N][8];
   int plen [N];
   int pptr [N];

   // monitor state
   logic [7:0] q_tx [$];
   int   rises = 0, hi_cnt = 0, stab_err = 0, rdy_pulses = 0, onehot_err = 0;
   logic [N-1:0] rdy_or = '0;
   logic tx_prev = 1'b0;
   logic [7:0] held = 8'h00;

   // controller model
   int cst = 0, ccnt = 0, rdy_dly = 0, ack_dly = 0;

   typedef struct {
      logic [N-1:0] mask;
      int           exp_gnt;
   } vec_t;
   vec_t vecs [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] req_byte(input int i);
      return 8'hA0 + 8'(8'h11 * i);
   endfunction

   task automatic drive_req();
      logic [N-1:0]   v, l;
      logic [8*N-1:0] d;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < N; i++) begin
         v[i] = (pptr[i] < plen[i]);
         l[i] = (pptr[i] == plen[i] - 1);
         d[8*i +: 8] = pm[i][(pptr[i] < 8) ? pptr[i] : 0];
      end
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) begin
         plen[i] = 0;
         pptr[i] = 0;
      end
      drive_req();
   endtask

   task automatic tick();
      logic rdy_v, ack_v;
      @(negedge clk);
      if (bus.tx && !tx_prev) begin
         q_tx.push_back(bus.data_tx);
         rises++;
         held = bus.data_tx;
      end else if (bus.tx && bus.data_tx !== held) begin
         stab_err++;
      end
      if (bus.tx) hi_cnt++;
      tx_prev = bus.tx;
      if (bus.req_ready != '0) begin
         rdy_pulses++;
         rdy_or |= bus.req_ready;
         if ($countones(bus.req_ready) != 1) onehot_err++;
      end
      for (int i = 0; i < N; i++)
         if (bus.req_ready[i] && pptr[i] < plen[i]) pptr[i]++;
      drive_req();
      rdy_v = 1'b0;
      ack_v = 1'b0;
      case (cst)
         0: if (bus.tx) begin
               if (rdy_dly == 0) begin rdy_v = 1'b1; cst = 2; end
               else begin ccnt = rdy_dly; cst = 1; end
            end
         1: begin
               ccnt--;
               if (ccnt == 0) begin rdy_v = 1'b1; cst = 2; end
            end
         2: begin
               if (ack_dly == 0) begin ack_v = 1'b1; cst = 0; end
               else begin ccnt = ack_dly; cst = 3; end
            end
         default: begin
               ccnt--;
               if (ccnt == 0) begin ack_v = 1'b1; cst = 0; end
            end
      endcase
      bus.tx_rdy_mon = rdy_v;
      bus.tx_ack_mon = ack_v;
   endtask

   task automatic wait_rises(input int target, input string nm);
      int c = 0;
      while (rises < target && c < 300) begin tick(); c++; end
      chk(nm, (rises >= target) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input string nm);
      int c = 0;
      while (bus.busy && c < 600) begin tick(); c++; end
      chk(nm, {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic load1(input int i, input logic [7:0] b);
      pm[i][0] = b;
      plen[i] = 1;
      pptr[i] = 0;
   endtask

   initial begin
      int r0, h0, p0, g, gchg;
      int idx;
      logic [7:0] exp_first;

      vecs[0]  = '{4'b0111, 0};
      vecs[1]  = '{4'b0111, 1};
      vecs[2]  = '{4'b0111, 2};
      vecs[3]  = '{4'b0111, 0};
      vecs[4]  = '{4'b1000, 3};
      vecs[5]  = '{4'b1001, 0};
      vecs[6]  = '{4'b0100, 2};
      vecs[7]  = '{4'b1010, 3};
      vecs[8]  = '{4'b1010, 1};
      vecs[9]  = '{4'b0010, 1};
      vecs[10] = '{4'b1111, 2};

      for (int i = 0; i < N; i++)
         for (int j = 0; j < 8; j++) pm[i][j] = 8'h00;
      clear_reqs();
      bus.tx_rdy_mon = 1'b0;
      bus.tx_ack_mon = 1'b0;
      rdy_dly = 0;
      ack_dly = 0;

      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      chk("reset tx", {31'd0, bus.tx}, 32'd0);
      chk("reset data_tx", {24'd0, bus.data_tx}, 32'h00);
      chk("reset req_ready", {28'd0, bus.req_ready}, 32'd0);
      chk("reset busy", {31'd0, bus.busy}, 32'd0);
      chk("reset grant_id", {30'd0, bus.grant_id}, 32'd0);

      // round-robin table: 1-byte packets from the requesters in mask
      rdy_dly = 0;
      ack_dly = 0;
      foreach (vecs[v]) begin
         for (int i = 0; i < N; i++) begin
            if (vecs[v].mask[i]) load1(i, req_byte(i));
            else begin plen[i] = 0; pptr[i] = 0; end
         end
         drive_req();
         r0 = rises;
         wait_rises(r0 + 1, $sformatf("rr%0d tx rise", v));
         chk($sformatf("rr%0d grant", v), {30'd0, bus.grant_id}, vecs[v].exp_gnt);
         chk($sformatf("rr%0d busy", v), {31'd0, bus.busy}, 32'd1);
         wait_idle($sformatf("rr%0d done", v));
         exp_first = (NB == 1) ? {4'hA, 4'(vecs[v].exp_gnt)} : req_byte(vecs[v].exp_gnt);
         idx = q_tx.size() - 1 - NB;
         chk($sformatf("rr%0d first byte", v), {24'd0, q_tx[idx]}, {24'd0, exp_first});
         chk($sformatf("rr%0d data", v), {24'd0, q_tx[q_tx.size()-1]}, {24'd0, req_byte(vecs[v].exp_gnt)});
      end

      // requester 0 sends 11 22 33
      clear_reqs();
      rdy_dly = 1;
      ack_dly = 2;
      pm[0][0] = 8'h11; pm[0][1] = 8'h22; pm[0][2] = 8'h33;
      plen[0] = 3; pptr[0] = 0;
      r0 = rises; h0 = hi_cnt; p0 = rdy_pulses; rdy_or = '0;
      drive_req();
      wait_rises(r0 + 1, "seq3 start");
      wait_idle("seq3 done");
      chk("seq3 tx count", rises - r0, 3 + NB);
      chk("seq3 byte0", {24'd0, q_tx[q_tx.size()-3]}, 32'h11);
      chk("seq3 byte1", {24'd0, q_tx[q_tx.size()-2]}, 32'h22);
      chk("seq3 byte2", {24'd0, q_tx[q_tx.size()-1]}, 32'h33);
      chk("seq3 ready pulses", rdy_pulses - p0, 3);
      chk("seq3 ready lanes", {28'd0, rdy_or}, 32'h1);
      chk("seq3 tx high cycles", hi_cnt - h0, 2 * (3 + NB));
      chk("seq3 busy after ack", {31'd0, bus.busy}, 32'd0);

      // controller holds tx_rdy_mon low for 10 cycles
      rdy_dly = 10;
      ack_dly = 1;
      load1(0, 8'h5A);
      r0 = rises; h0 = hi_cnt; stab_err = 0;
      drive_req();
      wait_rises(r0 + 1, "hold start");
      wait_idle("hold done");
      chk("hold tx high cycles", hi_cnt - h0, 11 * (1 + NB));
      chk("hold data stable", stab_err, 0);
      chk("hold tx count", rises - r0, 1 + NB);
      chk("hold data", {24'd0, q_tx[q_tx.size()-1]}, 32'h5A);

      // requester 1 mid-packet when requester 0 asks
      clear_reqs();
      rdy_dly = 1;
      ack_dly = 1;
      pm[1][0] = 8'h41; pm[1][1] = 8'h42; pm[1][2] = 8'h43; pm[1][3] = 8'h44;
      plen[1] = 4; pptr[1] = 0;
      r0 = rises; p0 = rdy_pulses;
      drive_req();
      g = 0;
      while (rdy_pulses < p0 + 2 && g < 300) begin tick(); g++; end
      chk("mid two bytes taken", rdy_pulses - p0, 2);
      load1(0, 8'h0F);
      drive_req();
      gchg = 0;
      g = 0;
      while (bus.busy && g < 600) begin
         tick();
         if (bus.busy && bus.grant_id != 2'd1) gchg++;
         g++;
      end
      chk("mid packet finished", {31'd0, bus.busy}, 32'd0);
      chk("mid no grant change", gchg, 0);
      chk("mid tx count", rises - r0, 4 + NB);
      chk("mid last byte", {24'd0, q_tx[q_tx.size()-1]}, 32'h44);
      chk("mid third byte", {24'd0, q_tx[q_tx.size()-2]}, 32'h43);
      r0 = rises;
      wait_rises(r0 + 1, "mid next start");
      chk("mid next grant", {30'd0, bus.grant_id}, 32'd0);
      wait_idle("mid next done");
      chk("mid next data", {24'd0, q_tx[q_tx.size()-1]}, 32'h0F);

      // requester 3 sends 0x55, optionally tagged
      clear_reqs();
      load1(3, 8'h55);
      r0 = rises;
      drive_req();
      wait_rises(r0 + 1, "tag start");
      chk("tag grant", {30'd0, bus.grant_id}, 32'd3);
      wait_idle("tag done");
      exp_first = (NB == 1) ? 8'hA3 : 8'h55;
      chk("tag tx count", rises - r0, 1 + NB);
      chk("tag first byte", {24'd0, q_tx[q_tx.size()-1-NB]}, {24'd0, exp_first});
      chk("tag payload", {24'd0, q_tx[q_tx.size()-1]}, 32'h55);

      // asynchronous reset while waiting for the ack of requester 2
      clear_reqs();
      rdy_dly = 1;
      ack_dly = 6;
      pm[2][0] = 8'h21; pm[2][1] = 8'h22;
      plen[2] = 2; pptr[2] = 0;
      drive_req();
      g = 0;
      while (cst != 3 && g < 300) begin tick(); g++; end
      chk("rst reached wait_ack", cst, 3);
      chk("rst pre grant", {30'd0, bus.grant_id}, 32'd2);
      chk("rst pre busy", {31'd0, bus.busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst async tx", {31'd0, bus.tx}, 32'd0);
      chk("rst async data_tx", {24'd0, bus.data_tx}, 32'h00);
      chk("rst async req_ready", {28'd0, bus.req_ready}, 32'd0);
      chk("rst async busy", {31'd0, bus.busy}, 32'd0);
      chk("rst async grant_id", {30'd0, bus.grant_id}, 32'd0);
      cst = 0;
      clear_reqs();
      load1(1, 8'hB1);
      load1(2, 8'hC2);
      drive_req();
      bus.tx_rdy_mon = 1'b0;
      bus.tx_ack_mon = 1'b0;
      tick(); tick();
      rst = 1'b0;
      ack_dly = 1;
      r0 = rises;
      wait_rises(r0 + 1, "post rst start");
      chk("post rst grant", {30'd0, bus.grant_id}, 32'd1);
      wait_idle("post rst done");
      chk("post rst data", {24'd0, q_tx[q_tx.size()-1]}, 32'hB1);

      chk("ready one-hot", onehot_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
